// File: rtl/nco_pkg.sv
// Shared types and default widths for the NCO frequency-sweep scheduler.
package nco_pkg;

    localparam int FSTEP_W_DFLT = 10;
    localparam int DWELL_W_DFLT = 16;
    localparam int NSTEP_W_DFLT = 8;

    localparam int FSTEP_MAX = (2 ** FSTEP_W_DFLT) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } sweep_dir_t;

endpackage

// File: rtl/nco_dwell_timer.sv
// Loadable down-counter; o_expire is high while the count sits at zero.
module nco_dwell_timer
    import nco_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DFLT
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_load_val,
    output logic               o_expire
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expire = (cnt_q == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep scheduler: steps the NCO tuning word with saturating arithmetic and a dwell per value.
module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int FSTEP_W = FSTEP_W_DFLT,
    parameter int DWELL_W = DWELL_W_DFLT,
    parameter int NSTEP_W = NSTEP_W_DFLT
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_mode,
    input  logic [FSTEP_W-1:0] i_f_start,
    input  logic [FSTEP_W-1:0] i_f_incr,
    input  logic [NSTEP_W-1:0] i_n_steps,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [FSTEP_W-1:0] o_freq_step,
    output logic               o_freq_valid,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_sat,
    output logic [NSTEP_W-1:0] o_step_idx
);

    localparam logic [FSTEP_W-1:0] F_MAX = {FSTEP_W{1'b1}};

    sweep_state_t       state_q, state_d;
    sweep_dir_t         dir_q, dir_d;
    logic               mode_q, mode_d;
    logic [FSTEP_W-1:0] incr_q, incr_d;
    logic [NSTEP_W-1:0] n_q, n_d;
    logic [DWELL_W-1:0] dwell_m1_q, dwell_m1_d;
    logic [FSTEP_W-1:0] freq_q, freq_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sat_q, sat_d;
    logic [NSTEP_W-1:0] idx_q, idx_d;

    logic               tmr_load;
    logic [DWELL_W-1:0] tmr_val;
    logic               tmr_expire;
    logic [DWELL_W-1:0] in_dwell_m1;

    logic [FSTEP_W:0]   up_sum, dn_diff;
    logic [FSTEP_W-1:0] up_val, dn_val;
    logic               up_clamp, dn_clamp;
    logic               step_en;
    sweep_dir_t         step_dir;

    assign in_dwell_m1 = (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);

    // One extra bit exposes the carry/borrow that decides the clamp.
    assign up_sum   = {1'b0, freq_q} + {1'b0, incr_q};
    assign dn_diff  = {1'b0, freq_q} - {1'b0, incr_q};
    assign up_clamp = up_sum[FSTEP_W];
    assign dn_clamp = dn_diff[FSTEP_W];
    assign up_val   = up_clamp ? F_MAX : up_sum[FSTEP_W-1:0];
    assign dn_val   = dn_clamp ? '0 : dn_diff[FSTEP_W-1:0];

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        mode_d     = mode_q;
        incr_d     = incr_q;
        n_d        = n_q;
        dwell_m1_d = dwell_m1_q;
        freq_d     = freq_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sat_d      = sat_q;
        idx_d      = idx_q;
        tmr_load   = 1'b0;
        tmr_val    = dwell_m1_q;
        step_en    = 1'b0;
        step_dir   = dir_q;

        unique case (state_q)
            IDLE: begin
                if (i_start && !i_abort) begin
                    state_d    = RUN;
                    dir_d      = DIR_UP;
                    mode_d     = i_mode;
                    incr_d     = i_f_incr;
                    n_d        = i_n_steps;
                    dwell_m1_d = in_dwell_m1;
                    freq_d     = i_f_start;
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                    sat_d      = 1'b0;
                    idx_d      = '0;
                    tmr_load   = 1'b1;
                    tmr_val    = in_dwell_m1;
                end
            end
            RUN: begin
                if (i_abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (tmr_expire) begin
                    tmr_load = 1'b1;
                    if (idx_q < n_q) begin
                        step_en = 1'b1;
                        idx_d   = idx_q + NSTEP_W'(1);
                    end else if (!mode_q) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (n_q != '0) begin
                        // The turning value is index 0 of the new leg; the step emitted here is index 1.
                        dir_d    = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
                        step_dir = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
                        step_en  = 1'b1;
                        idx_d    = NSTEP_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (step_en) begin
            valid_d = 1'b1;
            if (step_dir == DIR_UP) begin
                freq_d = up_val;
                sat_d  = sat_q | up_clamp;
            end else begin
                freq_d = dn_val;
                sat_d  = sat_q | dn_clamp;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            dir_q      <= DIR_UP;
            mode_q     <= 1'b0;
            incr_q     <= '0;
            n_q        <= '0;
            dwell_m1_q <= '0;
            freq_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            mode_q     <= mode_d;
            incr_q     <= incr_d;
            n_q        <= n_d;
            dwell_m1_q <= dwell_m1_d;
            freq_q     <= freq_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sat_q      <= sat_d;
            idx_q      <= idx_d;
        end
    end

    nco_dwell_timer #(
        .DWELL_W(DWELL_W)
    ) u_dwell_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (tmr_load),
        .i_load_val(tmr_val),
        .o_expire  (tmr_expire)
    );

    assign o_freq_step  = freq_q;
    assign o_freq_valid = valid_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_sat        = sat_q;
    assign o_step_idx   = idx_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed self-checking bench for nco_sweep_ctrl: sweeps, saturation, triangle, abort, edge cases, reset.
module tb_nco_sweep_ctrl;
    import nco_pkg::*;

    localparam int FW = 10;
    localparam int DW = 16;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          mode = 1'b0;
    logic [FW-1:0] f_start = '0;
    logic [FW-1:0] f_incr = '0;
    logic [NW-1:0] n_steps = '0;
    logic [DW-1:0] dwell = '0;
    logic [FW-1:0] freq;
    logic          valid;
    logic          busy;
    logic          done;
    logic          sat;
    logic [NW-1:0] idx;

    int total = 0;
    int bad = 0;
    int exp_f[$];
    int exp_s[$];

    nco_sweep_ctrl #(
        .FSTEP_W(FW),
        .DWELL_W(DW),
        .NSTEP_W(NW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_abort     (abort),
        .i_mode      (mode),
        .i_f_start   (f_start),
        .i_f_incr    (f_incr),
        .i_n_steps   (n_steps),
        .i_dwell     (dwell),
        .o_freq_step (freq),
        .o_freq_valid(valid),
        .o_busy      (busy),
        .o_done      (done),
        .o_sat       (sat),
        .o_step_idx  (idx)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input bit m, input int f0, input int inc, input int n, input int d);
        mode    = m;
        f_start = f0[FW-1:0];
        f_incr  = inc[FW-1:0];
        n_steps = n[NW-1:0];
        dwell   = d[DW-1:0];
    endtask

    task automatic start_sweep();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // Runs one single-mode sweep; exp_f/exp_s hold the expected value/sat per strobe.
    task automatic run_single(input string name, input int n, input int deff);
        int k;
        int c;
        int done_at;
        k = 0;
        c = 0;
        done_at = -1;
        start_sweep();
        check({name, "_busy_start"}, busy, 1);
        check({name, "_idx_start"}, idx, 0);
        while (done_at < 0 && c <= (n + 1) * deff + 8) begin
            if (valid) begin
                if (k < exp_f.size()) begin
                    check({name, "_freq"}, freq, exp_f[k]);
                    check({name, "_sat"}, sat, exp_s[k]);
                    check({name, "_idx"}, idx, k);
                end
                check({name, "_strobe_time"}, c, k * deff);
                k++;
            end
            if (done) begin
                done_at = c;
            end else begin
                tick();
                c++;
            end
        end
        check({name, "_n_strobes"}, k, n + 1);
        check({name, "_done_time"}, done_at, (n + 1) * deff);
        check({name, "_freq_final"}, freq, exp_f[n]);
        check({name, "_busy_done"}, busy, 0);
        check({name, "_valid_done"}, valid, 0);
        tick();
        check({name, "_done_one_cycle"}, done, 0);
        check({name, "_freq_hold"}, freq, exp_f[n]);
    endtask

    initial begin
        int k;
        int vcnt;
        int dcnt;
        int tri_v[4];

        tri_v[0] = 100;
        tri_v[1] = 110;
        tri_v[2] = 120;
        tri_v[3] = 110;

        #1 rst_n = 1'b0;
        #1;
        check("reset_freq", freq, 0);
        check("reset_valid", valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sat", sat, 0);
        check("reset_idx", idx, 0);
        #20 rst_n = 1'b1;
        tick();
        tick();
        check("idle_busy", busy, 0);

        // Saturation: 1000 -> 1023 -> 1023, sat sticky after first clamp.
        set_cfg(0, 1000, 50, 2, 4);
        exp_f.delete();
        exp_s.delete();
        exp_f.push_back(1000); exp_s.push_back(0);
        exp_f.push_back(FSTEP_MAX); exp_s.push_back(1);
        exp_f.push_back(1023); exp_s.push_back(1);
        run_single("satur", 2, 4);
        check("satur_sticky_idle", sat, 1);

        // Basic sweep (shortened dwell): 64,114,...,764; sat cleared by the new start.
        set_cfg(0, 64, 50, 14, 500);
        exp_f.delete();
        exp_s.delete();
        for (int i = 0; i <= 14; i++) begin
            exp_f.push_back(64 + 50 * i);
            exp_s.push_back(0);
        end
        run_single("basic", 14, 500);
        check("basic_sat_final", sat, 0);

        // D=0 behaves as D=1.
        set_cfg(0, 64, 50, 3, 0);
        exp_f.delete();
        exp_s.delete();
        for (int i = 0; i <= 3; i++) begin
            exp_f.push_back(64 + 50 * i);
            exp_s.push_back(0);
        end
        run_single("dwell0", 3, 1);

        // N=0 single sweep: one value, D cycles, done.
        set_cfg(0, 77, 9, 0, 6);
        exp_f.delete();
        exp_s.delete();
        exp_f.push_back(77);
        exp_s.push_back(0);
        run_single("n0_single", 0, 6);

        // Triangle: 100,110,120,110,100,... each held 3 cycles, never done.
        set_cfg(1, 100, 10, 2, 3);
        start_sweep();
        k = 0;
        dcnt = 0;
        for (int c = 0; c < 50; c++) begin
            if (valid) begin
                check("tri_freq", freq, tri_v[k % 4]);
                check("tri_strobe_time", c, k * 3);
                k++;
            end
            if (done) dcnt++;
            tick();
        end
        check("tri_n_strobes", k, 17);
        check("tri_no_done", dcnt, 0);
        check("tri_busy", busy, 1);
        // Abort lands on an expiry edge; abort wins and 100 holds.
        do_abort();
        check("tri_abort_busy", busy, 0);
        check("tri_abort_valid", valid, 0);
        check("tri_abort_freq", freq, 100);

        // N=0 triangle: hold f_start forever, no further strobes.
        set_cfg(1, 300, 5, 0, 2);
        start_sweep();
        check("n0_tri_freq0", freq, 300);
        check("n0_tri_valid0", valid, 1);
        vcnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (valid) vcnt++;
        end
        check("n0_tri_no_strobes", vcnt, 0);
        check("n0_tri_hold", freq, 300);
        check("n0_tri_busy", busy, 1);
        do_abort();
        check("n0_tri_abort_busy", busy, 0);

        // Abort at cycle 1200 of the basic sweep: third value (164) held, no done.
        set_cfg(0, 64, 50, 14, 500);
        start_sweep();
        repeat (1199) tick();
        do_abort();
        check("abort_busy", busy, 0);
        check("abort_freq", freq, 164);
        vcnt = 0;
        dcnt = 0;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (valid) vcnt++;
            if (done) dcnt++;
        end
        check("abort_no_valid", vcnt, 0);
        check("abort_no_done", dcnt, 0);
        check("abort_freq_hold", freq, 164);
        start_sweep();
        check("restart_freq", freq, 64);
        check("restart_idx", idx, 0);
        check("restart_busy", busy, 1);
        do_abort();

        // Start and abort in the same IDLE cycle: nothing starts.
        set_cfg(0, 500, 1, 3, 2);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_valid", valid, 0);
        check("start_abort_freq", freq, 64);
        tick();
        check("start_abort_busy2", busy, 0);

        // Start while busy is ignored; config changes are not picked up mid-sweep.
        set_cfg(0, 64, 50, 3, 4);
        start_sweep();
        set_cfg(0, 500, 7, 1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_valid", valid, 0);
        check("busy_start_freq", freq, 64);
        check("busy_start_idx", idx, 0);
        repeat (2) tick();
        check("latched_step_valid", valid, 0);
        tick();
        check("latched_step_strobe", valid, 1);
        check("latched_step_freq", freq, 114);
        check("latched_step_idx", idx, 1);
        do_abort();

        // Asynchronous reset mid-sweep after a clamp.
        set_cfg(0, 1000, 50, 2, 4);
        start_sweep();
        repeat (5) tick();
        check("pre_reset_sat", sat, 1);
        check("pre_reset_freq", freq, 1023);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_freq", freq, 0);
        check("async_rst_valid", valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_sat", sat, 0);
        check("async_rst_idx", idx, 0);
        #2 rst_n = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (valid || busy) vcnt++;
        end
        check("post_rst_idle", vcnt, 0);
        check("post_rst_freq", freq, 0);
        set_cfg(0, 64, 50, 1, 2);
        start_sweep();
        check("post_rst_start_freq", freq, 64);
        check("post_rst_start_busy", busy, 1);
        repeat (10) tick();
        check("post_rst_end_busy", busy, 0);
        check("post_rst_end_freq", freq, 114);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
